// File: rtl/cpri_rx_bfp_decomp.sv
// rtl/cpri_rx_bfp_decomp.sv - block-floating-point I/Q decompressor with RE/PRB/symbol tracking
// Optional mid-rise reconstruction is enabled by defining DZIP_RND_EN.
module cpri_rx_bfp_decomp #(
    parameter int NUM_PRB   = 132,
    parameter int NUM_RE    = 12,
    parameter int NUM_SYM   = 14,
    parameter int IN_W      = 7,
    parameter int OUT_W     = 16,
    parameter int MAX_SHIFT = 9
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_vld,
    input  logic                 i_sop,
    input  logic [2*IN_W-1:0]    i_iq,
    input  logic [3:0]           i_shift,
    output logic                 o_vld,
    output logic [2*OUT_W-1:0]   o_iq,
    output logic [10:0]          o_re_addr,
    output logic [3:0]           o_sym_idx,
    output logic                 o_eos,
    output logic                 o_err
);

    localparam logic [3:0]  MAX_SH   = 4'(MAX_SHIFT);
    localparam logic [3:0]  LAST_RE  = 4'(NUM_RE - 1);
    localparam logic [7:0]  LAST_PRB = 8'(NUM_PRB - 1);
    localparam logic [3:0]  LAST_SYM = 4'(NUM_SYM - 1);
    localparam logic [10:0] RE_PER_PRB = 11'(NUM_RE);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t state_q, state_d;
    logic [3:0] re_q, re_d;
    logic [7:0] prb_q, prb_d;
    logic [3:0] sym_q, sym_d;
    logic [3:0] shift_q, shift_d;

    logic            s1_vld_q, s1_vld_d;
    logic [IN_W-1:0] s1_i_q, s1_i_d;
    logic [IN_W-1:0] s1_qd_q, s1_qd_d;
    logic [3:0]      s1_shift_q, s1_shift_d;
    logic [10:0]     s1_addr_q, s1_addr_d;
    logic [3:0]      s1_sym_q, s1_sym_d;
    logic            s1_eos_q, s1_eos_d;
    logic            s1_err_q, s1_err_d;

    logic       sop_beat, premature, last_beat, shift_bad;
    logic [3:0] re_eff, sym_eff, shift_clamped, shift_eff;
    logic [7:0] prb_eff;

    function automatic logic [3:0] sym_inc(input logic [3:0] s);
        return (s == LAST_SYM) ? 4'd0 : s + 4'd1;
    endfunction

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            re_q       <= '0;
            prb_q      <= '0;
            sym_q      <= '0;
            shift_q    <= '0;
            s1_vld_q   <= 1'b0;
            s1_i_q     <= '0;
            s1_qd_q    <= '0;
            s1_shift_q <= '0;
            s1_addr_q  <= '0;
            s1_sym_q   <= '0;
            s1_eos_q   <= 1'b0;
            s1_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            re_q       <= re_d;
            prb_q      <= prb_d;
            sym_q      <= sym_d;
            shift_q    <= shift_d;
            s1_vld_q   <= s1_vld_d;
            s1_i_q     <= s1_i_d;
            s1_qd_q    <= s1_qd_d;
            s1_shift_q <= s1_shift_d;
            s1_addr_q  <= s1_addr_d;
            s1_sym_q   <= s1_sym_d;
            s1_eos_q   <= s1_eos_d;
            s1_err_q   <= s1_err_d;
        end
    end

    // An SOP beat always lands on address 0, whatever the counters say.
    always_comb begin
        sop_beat      = i_vld & i_sop;
        premature     = sop_beat && (state_q == S_RUN);
        re_eff        = sop_beat ? 4'd0 : re_q;
        prb_eff       = sop_beat ? 8'd0 : prb_q;
        sym_eff       = premature ? sym_inc(sym_q) : sym_q;
        shift_bad     = i_shift > MAX_SH;
        shift_clamped = shift_bad ? MAX_SH : i_shift;
        shift_eff     = (re_eff == 4'd0) ? shift_clamped : shift_q;
        last_beat     = (prb_eff == LAST_PRB) && (re_eff == LAST_RE);

        state_d    = state_q;
        re_d       = re_q;
        prb_d      = prb_q;
        sym_d      = sym_q;
        shift_d    = shift_q;
        s1_vld_d   = 1'b0;
        s1_i_d     = s1_i_q;
        s1_qd_d    = s1_qd_q;
        s1_shift_d = s1_shift_q;
        s1_addr_d  = s1_addr_q;
        s1_sym_d   = s1_sym_q;
        s1_eos_d   = 1'b0;
        s1_err_d   = 1'b0;

        if (i_vld) begin
            if (state_q == S_IDLE && !i_sop) begin
                s1_err_d = 1'b1;
            end else begin
                state_d    = S_RUN;
                s1_vld_d   = 1'b1;
                s1_i_d     = i_iq[2*IN_W-1:IN_W];
                s1_qd_d    = i_iq[IN_W-1:0];
                s1_shift_d = shift_eff;
                s1_addr_d  = {3'b0, prb_eff} * RE_PER_PRB + {7'b0, re_eff};
                s1_sym_d   = sym_eff;
                s1_eos_d   = last_beat;
                s1_err_d   = premature | ((re_eff == 4'd0) & shift_bad);
                shift_d    = shift_eff;
                sym_d      = sym_eff;
                if (last_beat) begin
                    state_d = S_IDLE;
                    re_d    = 4'd0;
                    prb_d   = 8'd0;
                    sym_d   = sym_inc(sym_eff);
                end else if (re_eff == LAST_RE) begin
                    re_d  = 4'd0;
                    prb_d = prb_eff + 8'd1;
                end else begin
                    re_d  = re_eff + 4'd1;
                    prb_d = prb_eff;
                end
            end
        end
    end

    logic signed [OUT_W-1:0] ext_i, ext_q, res_i, res_q;

    always_comb begin
        ext_i = {{(OUT_W-IN_W){s1_i_q[IN_W-1]}}, s1_i_q};
        ext_q = {{(OUT_W-IN_W){s1_qd_q[IN_W-1]}}, s1_qd_q};
        res_i = ext_i <<< s1_shift_q;
        res_q = ext_q <<< s1_shift_q;
`ifdef DZIP_RND_EN
        // Mid-rise: reconstruct to the centre of the quantisation step.
        if (s1_shift_q != 4'd0) begin
            res_i = res_i + (OUT_W'(1) << (s1_shift_q - 4'd1));
            res_q = res_q + (OUT_W'(1) << (s1_shift_q - 4'd1));
        end
`endif
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_vld     <= 1'b0;
            o_iq      <= '0;
            o_re_addr <= '0;
            o_sym_idx <= '0;
            o_eos     <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            o_vld <= s1_vld_q;
            o_err <= s1_err_q;
            o_eos <= s1_vld_q & s1_eos_q;
            if (s1_vld_q) begin
                o_iq      <= {res_i, res_q};
                o_re_addr <= s1_addr_q;
                o_sym_idx <= s1_sym_q;
            end
        end
    end

endmodule

// File: tb/tb_cpri_rx_bfp_decomp.sv
// tb/tb_cpri_rx_bfp_decomp.sv - scoreboard bench for cpri_rx_bfp_decomp (DZIP_RND_EN aware)
module tb_cpri_rx_bfp_decomp;

`ifdef DZIP_RND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif
    localparam int LAST = 1583;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_vld = 1'b0;
    logic        i_sop = 1'b0;
    logic [13:0] i_iq = '0;
    logic [3:0]  i_shift = '0;
    logic        o_vld;
    logic [31:0] o_iq;
    logic [10:0] o_re_addr;
    logic [3:0]  o_sym_idx;
    logic        o_eos;
    logic        o_err;

    cpri_rx_bfp_decomp dut (
        .i_clk(clk), .i_reset(i_reset), .i_vld(i_vld), .i_sop(i_sop),
        .i_iq(i_iq), .i_shift(i_shift), .o_vld(o_vld), .o_iq(o_iq),
        .o_re_addr(o_re_addr), .o_sym_idx(o_sym_idx), .o_eos(o_eos), .o_err(o_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] iq;
        logic [10:0] addr;
        logic [3:0]  sym;
        logic        eos;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   drop_err_seen = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!i_reset) begin
            if (o_vld) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat got addr=%0d sym=%0d", o_re_addr, o_sym_idx);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if ({o_iq, o_re_addr, o_sym_idx, o_eos, o_err} !== e) begin
                        errors++;
                        $display("FAIL beat got iq=%h addr=%0d sym=%0d eos=%b err=%b exp iq=%h addr=%0d sym=%0d eos=%b err=%b",
                                 o_iq, o_re_addr, o_sym_idx, o_eos, o_err,
                                 e.iq, e.addr, e.sym, e.eos, e.err);
                    end
                end
            end else if (o_err) begin
                drop_err_seen++;
            end
        end
    end

    task automatic beat(input logic sop, input logic [6:0] di, input logic [6:0] dq,
                        input logic [3:0] sh, input logic [15:0] ei, input logic [15:0] eq,
                        input int ea, input int es, input logic eeos, input logic eerr);
        exp_t e;
        i_vld   = 1'b1;
        i_sop   = sop;
        i_iq    = {di, dq};
        i_shift = sh;
        e.iq = {ei, eq}; e.addr = 11'(ea); e.sym = 4'(es); e.eos = eeos; e.err = eerr;
        sb.push_back(e);
        @(posedge clk); #1;
        i_vld = 1'b0;
        i_sop = 1'b0;
    endtask

    task automatic gap(input int n);
        i_vld = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int prb, re, s, w;
        logic [3:0]  sh;
        logic [6:0]  di, dq;
        logic [15:0] ei, eq;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_vld", 64'(o_vld), 64'd0);
        chk("reset_iq", 64'(o_iq), 64'd0);
        chk("reset_addr", 64'(o_re_addr), 64'd0);
        chk("reset_sym", 64'(o_sym_idx), 64'd0);
        chk("reset_eos", 64'(o_eos), 64'd0);
        chk("reset_err", 64'(o_err), 64'd0);
        i_reset = 1'b0;
        gap(2);

        // one full symbol, I=1 Q=-1 shift 3
        for (int a = 0; a <= LAST; a++)
            beat(a == 0, 7'sd1, -7'sd1, 4'd3, RND ? 16'sd12 : 16'sd8, RND ? -16'sd4 : -16'sd8,
                 a, 0, a == LAST, 1'b0);

        // exponent latch: PRB0 shift 2 (7 on RE5 ignored), PRB1 shift 0 (12 on later REs ignored)
        for (int a = 0; a <= LAST; a++) begin
            prb = a / 12; re = a % 12;
            if (prb == 0) begin
                sh = (re == 5) ? 4'd7 : 4'd2;
                ei = RND ? -16'sd254 : -16'sd256; eq = RND ? 16'sd2 : 16'sd0;
            end else if (prb == 1) begin
                sh = (re == 0) ? 4'd0 : 4'd12;
                ei = -16'sd64; eq = 16'sd0;
            end else begin
                sh = 4'd1;
                ei = RND ? -16'sd127 : -16'sd128; eq = RND ? 16'sd1 : 16'sd0;
            end
            beat(a == 0, -7'sd64, 7'sd0, sh, ei, eq, a, 1, a == LAST, 1'b0);
        end

        // clamp: PRB0 shift 13 -> 9 with error on its first beat only
        for (int a = 0; a <= LAST; a++) begin
            re = a % 12;
            sh = (re == 0) ? ((a == 0) ? 4'd13 : 4'd9) : 4'd13;
            beat(a == 0, 7'sd63, -7'sd64, sh, RND ? 16'sd32512 : 16'sd32256,
                 RND ? -16'sd32512 : -16'sh8000, a, 2, a == LAST, a == 0);
        end

        // dropped IDLE beat: error two cycles later with no valid
        i_vld = 1'b1; i_sop = 1'b0; i_iq = 14'h1234; i_shift = 4'd0;
        @(posedge clk); #1;
        i_vld = 1'b0;
        @(posedge clk); #1;
        chk("drop_err", 64'(o_err), 64'd1);
        chk("drop_vld", 64'(o_vld), 64'd0);
        gap(3);

        // premature SOP at address 700
        for (int a = 0; a < 700; a++)
            beat(a == 0, 7'sd5, -7'sd3, 4'd1, RND ? 16'sd11 : 16'sd10, RND ? -16'sd5 : -16'sd6,
                 a, 3, 1'b0, 1'b0);
        for (int a = 0; a <= LAST; a++)
            beat(a == 0, 7'sd5, -7'sd3, 4'd1, RND ? 16'sd11 : 16'sd10, RND ? -16'sd5 : -16'sd6,
                 a, 4, a == LAST, a == 0);

        // 14 symbols with random gaps, symbol index wraps 13 -> 0
        s = 5;
        for (int k = 0; k < 14; k++) begin
            for (int a = 0; a <= LAST; a++) begin
                beat(a == 0, -7'sd1, 7'sd2, 4'd0, -16'sd1, 16'sd2, a, s, a == LAST, 1'b0);
                if (a % 97 == 50) gap(int'($urandom_range(1, 5)));
            end
            s = (s + 1) % 14;
        end

        // reset mid-symbol while beats are in flight
        for (int a = 0; a < 300; a++)
            beat(a == 0, -7'sd1, 7'sd2, 4'd0, -16'sd1, 16'sd2, a, s, 1'b0, 1'b0);
        i_reset = 1'b1;
        #1;
        chk("midrst_vld", 64'(o_vld), 64'd0);
        chk("midrst_iq", 64'(o_iq), 64'd0);
        chk("midrst_addr", 64'(o_re_addr), 64'd0);
        chk("midrst_sym", 64'(o_sym_idx), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        i_reset = 1'b0;
        gap(2);

        // reconstruction vectors after reset: starts at addr 0, symbol 0
        for (int a = 0; a <= LAST; a++) begin
            prb = a / 12; re = a % 12;
            if (prb == 0) begin
                di = 7'sd0; dq = 7'sd0; sh = (re == 0) ? 4'd4 : 4'd15;
                ei = RND ? 16'sd8 : 16'sd0; eq = RND ? 16'sd8 : 16'sd0;
            end else if (prb == 1) begin
                di = 7'sd63; dq = 7'sd0; sh = (re == 0) ? 4'd9 : 4'd15;
                ei = RND ? 16'sd32512 : 16'sd32256; eq = RND ? 16'sd256 : 16'sd0;
            end else if (prb == 2) begin
                di = -7'sd7; dq = 7'sd7; sh = (re == 0) ? 4'd0 : 4'd15;
                ei = -16'sd7; eq = 16'sd7;
            end else begin
                di = 7'sd0; dq = 7'sd0; sh = 4'd0;
                ei = 16'sd0; eq = 16'sd0;
            end
            beat(a == 0, di, dq, sh, ei, eq, a, 0, a == LAST, 1'b0);
        end

        w = 0;
        while (sb.size() != 0 && w < 20) begin
            @(posedge clk);
            w++;
        end
        #1;
        chk("drain_empty", 64'(sb.size()), 64'd0);
        chk("drop_err_count", 64'(drop_err_seen), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
